cpsr_unit: RTL

- Producer side of the condition flags: owns the architectural CPSR (NZCV) that the condition checker consumes.
- Computes flags from EX-stage ALU results and handles MSR-style explicit flag writes.
- Saves/restores flags across exception entry/return on a small SPSR stack.
- Sits at the end of EX. Drives the registered CPSR plus a forwarded next-value for back-to-back conditional instructions.

---
 rtl/cpsr_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/cpsr_unit.sv
// rtl/cpsr_unit.sv - NZCV flag register with ALU/MSR update and SPSR stack for exception nesting
// Priority per cycle: exception entry, exception return, explicit write, ALU update, hold.
module cpsr_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validin,
  input  logic             shouldexecin,
  input  logic             setflagsin,
  input  logic             logicopin,
  input  logic [WIDTH-1:0] aluresultin,
  input  logic             alucarryin,
  input  logic             aluoverflowin,
  input  logic             shiftcarryin,
  input  logic             msrwritein,
  input  logic [3:0]       msrdatain,
  input  logic             excenterin,
  input  logic             excreturnin,
  output logic [3:0]       cpsrout,
  output logic [3:0]       cpsrfwdout,
  output logic [3:0]       spsrout,
  output logic             excactiveout,
  output logic             errout
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  logic [3:0]    cpsr;
  logic [3:0]    cpsr_next;
  logic [3:0]    stack [DEPTH];
  logic [3:0]    top;
  logic [3:0]    alu_flags;
  logic [DW-1:0] depth;
  logic [DW-1:0] depth_next;
  logic          push;
  logic          err;
  logic          err_next;
  logic          alu_en;

  // Flag layout is {V, N, C, Z}; logical ops keep V and take C from the shifter
  always_comb begin
    alu_flags = {logicopin ? cpsr[3] : aluoverflowin,
                 aluresultin[WIDTH-1],
                 logicopin ? shiftcarryin : alucarryin,
                 aluresultin == '0};
    alu_en    = validin & shouldexecin & setflagsin;
  end

  always_comb begin
    top = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    cpsr_next  = cpsr;
    depth_next = depth;
    push       = 1'b0;
    err_next   = 1'b0;
    if (excenterin) begin
      if (depth != DMAX) begin
        push       = 1'b1;
        depth_next = depth + DW'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (excreturnin) begin
      if (depth != '0) begin
        cpsr_next  = top;
        depth_next = depth - DW'(1);
      end else begin
        err_next = 1'b1;
      end
    end else if (msrwritein) begin
      cpsr_next = msrdatain;
    end else if (alu_en) begin
      cpsr_next = alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpsr  <= 4'b0000;
      depth <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= 4'b0000;
    end else begin
      cpsr  <= cpsr_next;
      depth <= depth_next;
      err   <= err_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && depth == DW'(i)) stack[i] <= cpsr;
      end
    end
  end

  assign cpsrout      = cpsr;
  assign cpsrfwdout   = cpsr_next;
  assign spsrout      = top;
  assign excactiveout = (depth != '0);
  assign errout       = err;

endmodule
